// File: rtl/ext_reset_pkg.sv
// Shared types and constants for the external reset requester.
package ext_reset_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    WAIT_LOW,
    WAIT_HIGH,
    HOLDOFF
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDOG = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  localparam logic [7:0] RST_COUNT_MAX = 8'd255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ext_reset_requester_sync_2ff.sv
// Single-bit two-flop synchronizer, synchronous active-high reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ext_reset_requester.sv
// Drives a minimum-width EXT_RST_N pulse and confirms the reset controller handshake.
// Optional watchdog request source enabled by defining EXT_RST_WATCHDOG_EN.
module ext_reset_requester
  import ext_reset_pkg::*;
#(
  parameter int PULSE_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int WDOG_CYCLES    = 1048576
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW_RST_REQ,
  input  logic       WDOG_KICK,
  input  logic       FABRIC_RESET_N,
  input  logic       PLL_LOCK,
  output logic       EXT_RST_N,
  output logic       BUSY,
  output logic       DONE,
  output logic       TIMEOUT_ERR,
  output logic [1:0] RST_CAUSE,
  output logic [7:0] RST_COUNT
);

  localparam int CNT_MAX = max3(PULSE_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYCLES - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ext_rst_n;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout_err;
  logic [1:0]      r_cause;
  logic [7:0]      r_count;

  logic w_fab_s;
  logic w_pll_s;
  logic w_wdog_exp;
  logic w_req;
  logic w_wl_adv;
  logic w_wh_adv;
  logic w_tmo;
  logic w_to_hold;

  sync_2ff u_sync_fab (.i_clk(CLK), .i_rst(RST), .i_d(FABRIC_RESET_N), .o_q(w_fab_s));
  sync_2ff u_sync_pll (.i_clk(CLK), .i_rst(RST), .i_d(PLL_LOCK),       .o_q(w_pll_s));

`ifdef EXT_RST_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LOAD = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] r_wdog;

  // A kick in the expiry cycle reloads and suppresses the request.
  assign w_wdog_exp = (r_state == IDLE) && (r_wdog == '0) && !WDOG_KICK;

  // r_done marks the first HOLDOFF cycle; the counter is frozen until then anyway.
  always_ff @(posedge CLK) begin
    if (RST)
      r_wdog <= WDOG_LOAD;
    else if (WDOG_KICK || r_done)
      r_wdog <= WDOG_LOAD;
    else if ((r_state == IDLE) && (r_wdog != '0))
      r_wdog <= r_wdog - 1'b1;
  end
`else
  logic w_unused_wdog;
  assign w_unused_wdog = WDOG_KICK | (WDOG_CYCLES == 0);
  assign w_wdog_exp    = 1'b0;
`endif

  assign w_req     = SW_RST_REQ | w_wdog_exp;
  assign w_wl_adv  = (r_state == WAIT_LOW)  && !w_fab_s;
  assign w_wh_adv  = (r_state == WAIT_HIGH) && w_fab_s && w_pll_s;
  assign w_tmo     = ((r_state == WAIT_LOW) || (r_state == WAIT_HIGH)) &&
                     (r_cnt == TMO_LAST) && !w_wl_adv && !w_wh_adv;
  assign w_to_hold = w_wh_adv | w_tmo;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_ext_rst_n   <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cause       <= CAUSE_NONE;
      r_count       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_cause     <= {w_wdog_exp, SW_RST_REQ};
            r_state     <= ASSERT;
            r_ext_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
          end
        end
        ASSERT: begin
          if (r_cnt == PULSE_LAST) begin
            r_state     <= WAIT_LOW;
            r_ext_rst_n <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_LOW, WAIT_HIGH: begin
          if (w_wl_adv) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
          end else if (!w_to_hold) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLDOFF: begin
          if (r_cnt == HOLD_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_ext_rst_n <= 1'b1;
          r_cnt       <= '0;
        end
      endcase

      // Both WAIT exits into HOLDOFF share the completion bookkeeping.
      if (w_to_hold) begin
        r_state <= HOLDOFF;
        r_cnt   <= '0;
        r_done  <= 1'b1;
        if (w_tmo)
          r_timeout_err <= 1'b1;
        if (r_count != RST_COUNT_MAX)
          r_count <= r_count + 1'b1;
      end
    end
  end

  assign EXT_RST_N   = r_ext_rst_n;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign TIMEOUT_ERR = r_timeout_err;
  assign RST_CAUSE   = r_cause;
  assign RST_COUNT   = r_count;

endmodule
